vram_frame_writer: RTL and testbench
====================================

Name: vram_frame_writer

Overview:
Write-side counterpart to the VGA scan-out path. It sweeps a frame's pixel coordinates in raster order and issues them to the Mandelbrot compute engine. It collects the in-order escape counts that come back and writes each one into VRAM at the tiled address the scan-out reader expects. The block sits between the compute engine and the VRAM write port of the BRAM array.

Parameters:
IMG_W, 256, frame width in pixels; range 1..256.
IMG_H, 256, frame height in lines; range 1..256.
MAX_OUTSTANDING, 8, maximum number of issued coordinates whose results have not yet been received; range 1..64.

Ports:
clk  in  1  pixel/system clock
reset_n  in  1  asynchronous, active-low reset
start  in  1  one-cycle request to render one frame
busy  out  1  high while a frame is in progress
frame_done  out  1  one-cycle pulse when the last pixel of the frame is written
req_valid  out  1  coordinate request valid
req_ready  in  1  compute engine accepts the request
req_x  out  9  pixel column of the request
req_y  out  9  pixel row of the request
res_valid  in  1  escape count valid
res_ready  out  1  block accepts the result
res_count  in  8  escape count (results arrive in request order)
VRAM_we  out  1  VRAM write enable
VRAM_waddr  out  18  VRAM write address
VRAM_wdata  out  8  VRAM write data

Behaviour:
- Reset (reset_n low, asynchronous):
  - All outputs are 0: busy, frame_done, req_valid, res_ready, VRAM_we, req_x, req_y, VRAM_waddr, VRAM_wdata.
  - All counters clear and the FSM enters IDLE.
  - Reset asserted mid-frame abandons the frame immediately. No further writes occur. Results still in flight after reset are ignored because res_ready is 0.
- FSM states:
  - IDLE: start=1 moves to ISSUE. The issue and write coordinates are cleared to (0,0) and the outstanding count to 0.
  - ISSUE: a request is accepted when req_valid and req_ready are both high. The coordinate then advances: x+1; at x=IMG_W-1, x goes to 0 and y increments. Accepting request (IMG_W-1, IMG_H-1) moves to DRAIN.
  - DRAIN: waits until all outstanding results are written, then returns to IDLE.
  - start is ignored outside IDLE.
- busy is high in ISSUE and DRAIN. It goes low the cycle after frame_done.
- Request channel:
  - req_valid = (state==ISSUE) && (outstanding < MAX_OUTSTANDING).
  - req_x and req_y are registered and stay stable while req_valid is high and req_ready is low.
- Outstanding counter:
  - Increments on a request handshake and decrements on a result handshake.
  - When both handshakes occur in the same cycle, the counter is unchanged.
  - It never exceeds MAX_OUTSTANDING and never underflows.
- Result channel:
  - res_ready = (state != IDLE) && (outstanding > 0).
  - res_valid while res_ready is low is ignored and not consumed.
- Write path (1-cycle latency):
  - A result handshake in cycle n produces VRAM_we=1 in cycle n+1.
  - VRAM_wdata is the res_count from cycle n.
  - VRAM_waddr is the tiled address of the write coordinate (wx,wy), which then advances in raster order like the issue coordinate.
  - VRAM_we is 0 in every cycle with no preceding result handshake.
  - Back-to-back results produce back-to-back writes.
- Address mapping, with x and y zero-extended to 9 bits: VRAM_waddr = {y[8:6], x[8:6], y[5:0], x[5:0]}.
  - [17:15] = block row, [14:12] = block column, [11:6] = local row, [5:0] = local column.
- frame_done pulses high in the same cycle as the VRAM_we for pixel (IMG_W-1, IMG_H-1).
- The FSM is in IDLE on the next cycle after frame_done, so a start in that cycle is accepted.
- Exactly IMG_W*IMG_H writes occur per frame. No address is written twice.

Test Plan:
- Full 256x256 frame; req_ready and res_valid tied high with the engine echoing count = x^y -> 65536 writes.
  - Pixel (65,130) is written to address 69761 with data 0xC3.
  - Pixel (255,255) is written to address 114687.
  - frame_done pulses once, coincident with the final write.
- MAX_OUTSTANDING=8, res_valid held low -> exactly 8 requests (0,0)..(7,0) are issued, then req_valid=0.
  - One result then re-enables exactly one request, (8,0).
- req_ready toggled pseudo-randomly -> req_x and req_y stay stable during stalls, no coordinate is skipped or duplicated, and the write-address sequence matches the raster order.
- IMG_W=4, IMG_H=3 -> 12 writes to addresses 0,1,2,3,64,65,66,67,128,129,130,131.
  - busy is high from the cycle after start until the cycle of frame_done, then low.
- start pulsed again mid-frame -> ignored, with write count unchanged.
  - start in the cycle after frame_done -> a new frame begins at (0,0).
- reset_n asserted mid-frame with 5 results pending -> all outputs are 0 immediately, there are no writes afterwards, and the next start renders a full, correct frame.

Source files
------------

// File: rtl/vram_frame_writer.sv
// vram_frame_writer
//   Sweeps one frame of pixel coordinates in raster order, hands them to the
//   Mandelbrot compute engine, and writes the in-order escape counts that come
//   back into VRAM at the tiled address used by the scan-out reader.
//
// Ports
//   clk, reset_n        clock, asynchronous active-low reset
//   start               one-cycle request to render a frame (only seen in IDLE)
//   busy                high while a frame is being issued or drained
//   frame_done          one-cycle pulse with the write of the last pixel
//   req_valid/ready     coordinate request handshake, req_x/req_y coordinate
//   res_valid/ready     escape count handshake, res_count count (in order)
//   VRAM_we/waddr/wdata VRAM write port
module vram_frame_writer #(
    parameter int IMG_W           = 256,
    parameter int IMG_H           = 256,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    output logic        busy,
    output logic        frame_done,
    output logic        req_valid,
    input  logic        req_ready,
    output logic [8:0]  req_x,
    output logic [8:0]  req_y,
    input  logic        res_valid,
    output logic        res_ready,
    input  logic [7:0]  res_count,
    output logic        VRAM_we,
    output logic [17:0] VRAM_waddr,
    output logic [7:0]  VRAM_wdata
);

    localparam int              OUT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUTSTANDING);
    localparam logic [8:0]      X_LAST  = 9'(IMG_W - 1);
    localparam logic [8:0]      Y_LAST  = 9'(IMG_H - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [8:0]       ix_q, iy_q;      // next coordinate to issue
    logic [8:0]       wx_q, wy_q;      // coordinate of the next result to write
    logic [OUT_W-1:0] outstanding_q;

    logic req_hs_p0, res_hs_p0;

    logic        vld_p1;
    logic        last_p1;
    logic [17:0] waddr_p1;
    logic [7:0]  wdata_p1;

    // Scan-out reads VRAM in 64x64 tiles: block row, block column, then the
    // position inside the tile.
    function automatic logic [17:0] tile_addr(input logic [8:0] x, input logic [8:0] y);
        return {y[8:6], x[8:6], y[5:0], x[5:0]};
    endfunction

    assign req_hs_p0 = req_valid && req_ready;
    assign res_hs_p0 = res_valid && res_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        busy      = 1'b0;
        req_valid = 1'b0;
        res_ready = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                busy      = 1'b1;
                req_valid = (outstanding_q < OUT_MAX);
                res_ready = (outstanding_q != '0);
                if (req_ready && (outstanding_q < OUT_MAX) &&
                    (ix_q == X_LAST) && (iy_q == Y_LAST)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                busy      = 1'b1;
                res_ready = (outstanding_q != '0);
                // The final write is on the port this cycle; leave after it.
                if (last_p1) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ---- stage p0: handshakes, coordinate and outstanding bookkeeping ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ix_q          <= '0;
            iy_q          <= '0;
            wx_q          <= '0;
            wy_q          <= '0;
            outstanding_q <= '0;
        end else if ((state_q == IDLE) && start) begin
            ix_q          <= '0;
            iy_q          <= '0;
            wx_q          <= '0;
            wy_q          <= '0;
            outstanding_q <= '0;
        end else begin
            if (req_hs_p0) begin
                if (ix_q == X_LAST) begin
                    ix_q <= '0;
                    iy_q <= (iy_q == Y_LAST) ? 9'd0 : iy_q + 9'd1;
                end else begin
                    ix_q <= ix_q + 9'd1;
                end
            end
            if (res_hs_p0) begin
                if (wx_q == X_LAST) begin
                    wx_q <= '0;
                    wy_q <= (wy_q == Y_LAST) ? 9'd0 : wy_q + 9'd1;
                end else begin
                    wx_q <= wx_q + 9'd1;
                end
            end
            case ({req_hs_p0, res_hs_p0})
                2'b10:   outstanding_q <= outstanding_q + OUT_W'(1);
                2'b01:   outstanding_q <= outstanding_q - OUT_W'(1);
                default: outstanding_q <= outstanding_q;
            endcase
        end
    end

    // ---- stage p1: registered VRAM write ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p1   <= 1'b0;
            last_p1  <= 1'b0;
            waddr_p1 <= '0;
            wdata_p1 <= '0;
        end else begin
            vld_p1  <= res_hs_p0;
            last_p1 <= res_hs_p0 && (wx_q == X_LAST) && (wy_q == Y_LAST);
            if (res_hs_p0) begin
                waddr_p1 <= tile_addr(wx_q, wy_q);
                wdata_p1 <= res_count;
            end
        end
    end

    assign req_x      = ix_q;
    assign req_y      = iy_q;
    assign VRAM_we    = vld_p1;
    assign VRAM_waddr = waddr_p1;
    assign VRAM_wdata = wdata_p1;
    assign frame_done = last_p1;

endmodule

// File: tb/tb_vram_frame_writer.sv
// tb_vram_frame_writer
//   Two writers: a 256x256 frame and a 4x3 frame. A compute-engine model
//   answers requests in order; every accepted request pushes the expected VRAM
//   write into a scoreboard which a monitor pops on each VRAM_we.
module tb_vram_frame_writer;

    typedef struct {
        int x;
        int y;
        int d;
        bit last;
    } wr_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n      [2];
    logic        start      [2];
    logic        busy       [2];
    logic        frame_done [2];
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic [8:0]  req_x      [2];
    logic [8:0]  req_y      [2];
    logic        res_valid  [2];
    logic        res_ready  [2];
    logic [7:0]  res_count  [2];
    logic        vram_we    [2];
    logic [17:0] vram_waddr [2];
    logic [7:0]  vram_wdata [2];

    vram_frame_writer #(.IMG_W(256), .IMG_H(256), .MAX_OUTSTANDING(8)) u_big (
        .clk(clk), .reset_n(rst_n[0]), .start(start[0]), .busy(busy[0]),
        .frame_done(frame_done[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_x(req_x[0]), .req_y(req_y[0]), .res_valid(res_valid[0]),
        .res_ready(res_ready[0]), .res_count(res_count[0]), .VRAM_we(vram_we[0]),
        .VRAM_waddr(vram_waddr[0]), .VRAM_wdata(vram_wdata[0])
    );

    vram_frame_writer #(.IMG_W(4), .IMG_H(3), .MAX_OUTSTANDING(8)) u_small (
        .clk(clk), .reset_n(rst_n[1]), .start(start[1]), .busy(busy[1]),
        .frame_done(frame_done[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_x(req_x[1]), .req_y(req_y[1]), .res_valid(res_valid[1]),
        .res_ready(res_ready[1]), .res_count(res_count[1]), .VRAM_we(vram_we[1]),
        .VRAM_waddr(vram_waddr[1]), .VRAM_wdata(vram_wdata[1])
    );

    int n_pass  = 0;
    int n_total = 0;

    // req_mode: 0 never ready, 1 always, 2 random, 4 ready while fewer than 5 pending
    // res_mode: 0 none, 1 always, 2 random, 3 a single result, 5 junk res_valid
    int         req_mode [2];
    int         res_mode [2];
    logic [7:0] ret_q    [2][$];
    wr_t        sb_q     [2][$];
    int         ex [2], ey [2];
    int         wcount [2], fd_count [2], reqs_acc [2];
    bit         busy_chk [2], stalled [2];
    int         sx [2], sy [2];
    int         small_addrs [12] = '{0, 1, 2, 3, 64, 65, 66, 67, 128, 129, 130, 131};

    function automatic int img_w(input int g);
        return (g == 0) ? 256 : 4;
    endfunction

    function automatic int img_h(input int g);
        return (g == 0) ? 256 : 3;
    endfunction

    // 64x64 tiles laid out row-major, 8 tiles per tile row.
    function automatic int model_addr(input int x, input int y);
        return (y / 64) * 32768 + (x / 64) * 4096 + (y % 64) * 64 + (x % 64);
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic chk_zero(input int g);
        check("rst_busy", busy[g], 0);
        check("rst_frame_done", frame_done[g], 0);
        check("rst_req_valid", req_valid[g], 0);
        check("rst_res_ready", res_ready[g], 0);
        check("rst_vram_we", vram_we[g], 0);
        check("rst_req_x", req_x[g], 0);
        check("rst_req_y", req_y[g], 0);
        check("rst_vram_waddr", vram_waddr[g], 0);
        check("rst_vram_wdata", vram_wdata[g], 0);
    endtask

    task automatic pulse_start(input int g);
        @(negedge clk);
        start[g] = 1'b1;
        @(negedge clk);
        start[g] = 1'b0;
    endtask

    task automatic wait_done(input int g, input int budget, input string name);
        bit seen;
        seen = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (frame_done[g]) begin
                seen = 1;
                break;
            end
        end
        check(name, seen, 1);
    endtask

    // Engine model plus write monitor, both evaluated on the falling edge.
    initial begin : bfm
        bit  rv, rr, last;
        int  d;
        wr_t e;
        for (int g = 0; g < 2; g++) begin
            req_ready[g] = 1'b0;
            res_valid[g] = 1'b0;
            res_count[g] = 8'd0;
        end
        forever begin
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                if (!rst_n[g]) begin
                    stalled[g]  = 0;
                    busy_chk[g] = 0;
                    continue;
                end
                if (busy_chk[g]) begin
                    check("busy_after_done", busy[g], 0);
                    busy_chk[g] = 0;
                end
                if (vram_we[g]) begin
                    if (sb_q[g].size() == 0) begin
                        check("unexpected_write", 1, 0);
                    end else begin
                        e = sb_q[g].pop_front();
                        check("waddr", vram_waddr[g], model_addr(e.x, e.y));
                        check("wdata", vram_wdata[g], e.d);
                        check("frame_done_at_write", frame_done[g], e.last);
                        if (g == 1 && wcount[g] < 12)
                            check("small_addr_list", vram_waddr[g], small_addrs[wcount[g]]);
                        if (g == 0 && e.x == 65 && e.y == 130) begin
                            check("px65_130_addr", vram_waddr[g], 69761);
                            check("px65_130_data", vram_wdata[g], 'hC3);
                        end
                        if (g == 0 && e.last)
                            check("px255_255_addr", vram_waddr[g], 114687);
                        wcount[g]++;
                        if (e.last) begin
                            check("writes_per_frame", wcount[g], img_w(g) * img_h(g));
                            check("busy_at_done", busy[g], 1);
                            wcount[g]   = 0;
                            busy_chk[g] = 1;
                        end
                    end
                end else if (frame_done[g]) begin
                    check("frame_done_without_write", 1, 0);
                end
                if (frame_done[g]) fd_count[g]++;

                if (stalled[g] && req_valid[g]) begin
                    check("stall_req_x", req_x[g], sx[g]);
                    check("stall_req_y", req_y[g], sy[g]);
                end

                case (res_mode[g])
                    1, 3:    rv = (ret_q[g].size() > 0);
                    2:       rv = (ret_q[g].size() > 0) && ($urandom_range(0, 1) == 1);
                    5:       rv = 1;
                    default: rv = 0;
                endcase
                res_valid[g] = rv;
                if (rv && res_mode[g] != 5) res_count[g] = ret_q[g][0];
                else                        res_count[g] = 8'($urandom);
                if (rv && res_mode[g] != 5 && res_ready[g]) begin
                    void'(ret_q[g].pop_front());
                    if (res_mode[g] == 3) res_mode[g] = 0;
                end

                case (req_mode[g])
                    1:       rr = 1;
                    2:       rr = ($urandom_range(0, 3) != 0);
                    4:       rr = (ret_q[g].size() < 5);
                    default: rr = 0;
                endcase
                req_ready[g] = rr;
                if (req_valid[g] && rr) begin
                    check("req_x", req_x[g], ex[g]);
                    check("req_y", req_y[g], ey[g]);
                    d    = (g == 0) ? ((ex[g] ^ ey[g]) & 255) : int'($urandom_range(0, 255));
                    last = (ex[g] == img_w(g) - 1) && (ey[g] == img_h(g) - 1);
                    ret_q[g].push_back(8'(d));
                    sb_q[g].push_back(wr_t'{ex[g], ey[g], d, last});
                    reqs_acc[g]++;
                    if (ex[g] == img_w(g) - 1) begin
                        ex[g] = 0;
                        ey[g] = last ? 0 : ey[g] + 1;
                    end else begin
                        ex[g] = ex[g] + 1;
                    end
                end
                stalled[g] = req_valid[g] && !rr;
                sx[g]      = req_x[g];
                sy[g]      = req_y[g];
            end
        end
    end

    initial begin : main
        for (int g = 0; g < 2; g++) begin
            rst_n[g] = 1'b1; start[g] = 1'b0;
            req_mode[g] = 0; res_mode[g] = 0;
            ex[g] = 0; ey[g] = 0; wcount[g] = 0; fd_count[g] = 0; reqs_acc[g] = 0;
            busy_chk[g] = 0; stalled[g] = 0; sx[g] = 0; sy[g] = 0;
        end
        #2;
        rst_n[0] = 1'b0;
        rst_n[1] = 1'b0;
        #1;
        chk_zero(0);
        chk_zero(1);
        repeat (3) @(negedge clk);
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;

        // Big frame: outstanding limit, one-result refill, then the full frame.
        check("big_idle_busy", busy[0], 0);
        req_mode[0] = 1;
        pulse_start(0);
        check("big_busy_after_start", busy[0], 1);
        repeat (20) @(negedge clk);
        #1;
        check("big_reqs_at_limit", reqs_acc[0], 8);
        check("big_req_valid_at_limit", req_valid[0], 0);
        check("big_res_ready_pending", res_ready[0], 1);
        res_mode[0] = 3;
        repeat (6) @(negedge clk);
        #1;
        check("big_reqs_after_one_result", reqs_acc[0], 9);
        check("big_pending_after_refill", ret_q[0].size(), 8);
        check("big_req_valid_refilled", req_valid[0], 0);
        res_mode[0] = 1;
        repeat (50) @(negedge clk);
        pulse_start(0);
        wait_done(0, 70000, "big_frame_done");
        repeat (5) @(negedge clk);
        #1;
        check("big_frame_done_once", fd_count[0], 1);
        check("big_sb_empty", sb_q[0].size(), 0);
        check("big_busy_idle", busy[0], 0);

        // Small frame 1: random backpressure with a mid-frame start.
        check("small_idle_busy", busy[1], 0);
        req_mode[1] = 2;
        res_mode[1] = 2;
        pulse_start(1);
        check("small_busy_after_start", busy[1], 1);
        repeat (2) @(negedge clk);
        pulse_start(1);
        wait_done(1, 1000, "small_frame1_done");

        // Frame 2 starts in the cycle right after frame_done.
        req_mode[1] = 1;
        res_mode[1] = 1;
        pulse_start(1);
        check("small_restart_busy", busy[1], 1);
        wait_done(1, 200, "small_frame2_done");

        // Frame 3: reset with 5 results in flight.
        req_mode[1] = 4;
        res_mode[1] = 0;
        pulse_start(1);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            #1;
            if (ret_q[1].size() == 5) break;
        end
        check("small_pending5", ret_q[1].size(), 5);
        @(negedge clk);
        #2;
        rst_n[1] = 1'b0;
        #1;
        chk_zero(1);
        res_mode[1] = 5;
        req_mode[1] = 1;
        ret_q[1].delete();
        sb_q[1].delete();
        ex[1] = 0; ey[1] = 0; wcount[1] = 0;
        repeat (3) @(negedge clk);
        rst_n[1] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            check("post_reset_vram_we", vram_we[1], 0);
            check("post_reset_res_ready", res_ready[1], 0);
        end

        // Frame 4: full frame after the reset.
        res_mode[1] = 1;
        req_mode[1] = 2;
        pulse_start(1);
        wait_done(1, 1000, "small_frame4_done");
        repeat (4) @(negedge clk);
        #1;
        check("small_frames_completed", fd_count[1], 3);
        check("small_sb_empty", sb_q[1].size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
